// File: rtl/cruise_cmd_sequencer.sv
// Arbitrates button/remote cruise commands, checks legality and drives fixed-width pulses.
// Optional drop statistics counter enabled by defining CRUISE_SEQ_STATS_EN.
module cruise_cmd_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned MIN_SPEED   = 45
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_valid,
    input  logic [2:0] i_btn_cmd,
    output logic       o_btn_ready,
    input  logic       i_rmt_valid,
    input  logic [2:0] i_rmt_cmd,
    output logic       o_rmt_ready,
    input  logic       i_brake_in,
    input  logic [7:0] i_speed,
    input  logic [7:0] i_cruisespeed,
    input  logic       i_cruisectrl,
    output logic       o_set,
    output logic       o_accel,
    output logic       o_coast,
    output logic       o_cancel,
    output logic       o_resume,
    output logic       o_brake,
    output logic       o_reject,
    output logic       o_reject_src,
`ifdef CRUISE_SEQ_STATS_EN
    output logic [7:0] o_drop_count,
`endif
    output logic       o_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_REJ   = 2'd3;

    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD    = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [7:0] MIN_SPEED_V = 8'(MIN_SPEED);

    logic [1:0] r_state;
    logic       r_ptr;
    logic [3:0] r_cnt;
    logic [4:0] r_pulse;
    logic       r_reject;
    logic       r_reject_src;
    logic       r_brake;

    logic       w_can_accept;
    logic       w_grant_btn;
    logic       w_grant_rmt;
    logic       w_accept;
    logic [2:0] w_cmd;
    logic       w_legal;
    logic [4:0] w_onehot;

    // r_ptr = 0 favours btn when both requesters are valid.
    always_comb begin
        w_can_accept = (r_state == ST_IDLE) && !i_brake_in;
        w_grant_btn  = i_btn_valid && (!i_rmt_valid || !r_ptr);
        w_grant_rmt  = i_rmt_valid && (!i_btn_valid || r_ptr);
        o_btn_ready  = w_can_accept && w_grant_btn;
        o_rmt_ready  = w_can_accept && w_grant_rmt;
        w_accept     = o_btn_ready || o_rmt_ready;
        w_cmd        = w_grant_rmt ? i_rmt_cmd : i_btn_cmd;
    end

    always_comb begin
        w_legal  = 1'b0;
        w_onehot = 5'b00000;
        case (w_cmd)
            3'd1: begin
                w_legal  = !i_cruisectrl && (i_speed > MIN_SPEED_V);
                w_onehot = 5'b00001;
            end
            3'd2: begin
                w_legal  = i_cruisectrl;
                w_onehot = 5'b00010;
            end
            3'd3: begin
                w_legal  = i_cruisectrl;
                w_onehot = 5'b00100;
            end
            3'd4: begin
                w_legal  = i_cruisectrl;
                w_onehot = 5'b01000;
            end
            3'd5: begin
                w_legal  = !i_cruisectrl && (i_cruisespeed != 8'd0);
                w_onehot = 5'b10000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_cnt        <= 4'd0;
            r_pulse      <= 5'b00000;
            r_reject     <= 1'b0;
            r_reject_src <= 1'b0;
            r_brake      <= 1'b0;
        end else begin
            r_brake <= i_brake_in;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ptr <= ~r_ptr;
                        if (w_legal) begin
                            r_state <= ST_DRIVE;
                            r_pulse <= w_onehot;
                            r_cnt   <= HOLD_LOAD;
                        end else begin
                            r_state      <= ST_REJ;
                            r_reject     <= 1'b1;
                            r_reject_src <= w_grant_rmt;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (i_brake_in) begin
                        r_state <= ST_IDLE;
                        r_pulse <= 5'b00000;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_pulse <= 5'b00000;
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= GAP_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (i_brake_in || (r_cnt == 4'd0)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    // Reject always completes its single cycle, brake or not.
                    r_state      <= ST_IDLE;
                    r_reject     <= 1'b0;
                    r_reject_src <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRUISE_SEQ_STATS_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_drop_count <= 8'd0;
        end else if (w_accept && !w_legal && (r_drop_count != 8'd255)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

    assign o_set        = r_pulse[0];
    assign o_accel      = r_pulse[1];
    assign o_coast      = r_pulse[2];
    assign o_cancel     = r_pulse[3];
    assign o_resume     = r_pulse[4];
    assign o_reject     = r_reject;
    assign o_reject_src = r_reject_src;
    assign o_brake      = r_brake;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cruise_cmd_sequencer.sv
// Bench for cruise_cmd_sequencer: vector table, directed corner sequences, random vs model.
// Drop counter checks are included when CRUISE_SEQ_STATS_EN is defined.
module tb_cruise_cmd_sequencer;

    localparam int HOLD = 1;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_valid = 1'b0;
    logic [2:0] btn_cmd = 3'd0;
    logic       rmt_valid = 1'b0;
    logic [2:0] rmt_cmd = 3'd0;
    logic       brake_in = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [7:0] cruisespeed = 8'd0;
    logic       cruisectrl = 1'b0;

    logic btn_ready, rmt_ready, set, accel, coast, cancel, resume, brake, reject, reject_src, busy;
    logic btn_ready3, rmt_ready3, set3, accel3, coast3, cancel3, resume3;
    logic brake3, reject3, reject_src3, busy3;
`ifdef CRUISE_SEQ_STATS_EN
    logic [7:0] drop_count, drop_count3;
`endif
    logic [4:0] pulse, pulse3;

    assign pulse  = {resume, cancel, coast, accel, set};
    assign pulse3 = {resume3, cancel3, coast3, accel3, set3};

    always #5 clk = ~clk;

    cruise_cmd_sequencer u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_btn_valid(btn_valid), .i_btn_cmd(btn_cmd), .o_btn_ready(btn_ready),
        .i_rmt_valid(rmt_valid), .i_rmt_cmd(rmt_cmd), .o_rmt_ready(rmt_ready),
        .i_brake_in(brake_in), .i_speed(speed), .i_cruisespeed(cruisespeed),
        .i_cruisectrl(cruisectrl),
        .o_set(set), .o_accel(accel), .o_coast(coast), .o_cancel(cancel), .o_resume(resume),
        .o_brake(brake), .o_reject(reject), .o_reject_src(reject_src),
`ifdef CRUISE_SEQ_STATS_EN
        .o_drop_count(drop_count),
`endif
        .o_busy(busy)
    );

    cruise_cmd_sequencer #(.HOLD_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst),
        .i_btn_valid(btn_valid), .i_btn_cmd(btn_cmd), .o_btn_ready(btn_ready3),
        .i_rmt_valid(rmt_valid), .i_rmt_cmd(rmt_cmd), .o_rmt_ready(rmt_ready3),
        .i_brake_in(brake_in), .i_speed(speed), .i_cruisespeed(cruisespeed),
        .i_cruisectrl(cruisectrl),
        .o_set(set3), .o_accel(accel3), .o_coast(coast3), .o_cancel(cancel3),
        .o_resume(resume3), .o_brake(brake3), .o_reject(reject3), .o_reject_src(reject_src3),
`ifdef CRUISE_SEQ_STATS_EN
        .o_drop_count(drop_count3),
`endif
        .o_busy(busy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_valid = 1'b0;
        rmt_valid = 1'b0;
        brake_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    function automatic bit is_legal(int code, bit ctrl, int spd, int cs);
        case (code)
            1: return !ctrl && spd > 45;
            2, 3, 4: return ctrl;
            5: return !ctrl && cs != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model: tracks windows of cycles instead of a state machine.
    int cyc, m_idle_from, m_pfirst, m_plast, m_code, m_rej, m_drops;
    bit m_ptr, m_rsrc, m_brake;

    task automatic model_init();
        cyc = 0;
        m_idle_from = 0;
        m_pfirst = 1;
        m_plast = 0;
        m_code = 1;
        m_rej = -1;
        m_rsrc = 1'b0;
        m_ptr = 1'b0;
        m_brake = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step();
        bit src;
        int code;
        m_brake = brake_in;
        if (cyc - 1 >= m_idle_from) begin
            if (!brake_in && (btn_valid || rmt_valid)) begin
                src = rmt_valid && (!btn_valid || m_ptr);
                code = src ? int'(rmt_cmd) : int'(btn_cmd);
                m_ptr = !m_ptr;
                if (is_legal(code, cruisectrl, int'(speed), int'(cruisespeed))) begin
                    m_code = code;
                    m_pfirst = cyc;
                    m_plast = cyc + HOLD - 1;
                    m_idle_from = cyc + HOLD + GAP;
                end else begin
                    m_rej = cyc;
                    m_rsrc = src;
                    m_idle_from = cyc + 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end else if (brake_in) begin
            if (m_plast > cyc - 1) m_plast = cyc - 1;
            m_idle_from = cyc;
        end
    endtask

    task automatic rand_drive();
        btn_valid = 1'($urandom_range(0, 1));
        btn_cmd = 3'($urandom_range(0, 7));
        rmt_valid = 1'($urandom_range(0, 1));
        rmt_cmd = 3'($urandom_range(0, 7));
        cruisectrl = 1'($urandom_range(0, 1));
        speed = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(40, 50)) : 8'($urandom_range(0, 255));
        cruisespeed = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        brake_in = ($urandom_range(0, 9) == 0);
    endtask

    typedef struct {
        logic [2:0] cmd;
        bit         src;
        bit         ctrl;
        logic [7:0] spd;
        logic [7:0] cs;
        logic [4:0] exp_pulse;
        bit         exp_rej;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [4:0] ep;
        bit idle, can;

        vecs[0]  = '{3'd1, 1'b0, 1'b0, 8'd50, 8'd0,  5'b00001, 1'b0};
        vecs[1]  = '{3'd1, 1'b0, 1'b0, 8'd45, 8'd0,  5'b00000, 1'b1};
        vecs[2]  = '{3'd1, 1'b1, 1'b0, 8'd46, 8'd0,  5'b00001, 1'b0};
        vecs[3]  = '{3'd1, 1'b0, 1'b1, 8'd90, 8'd0,  5'b00000, 1'b1};
        vecs[4]  = '{3'd2, 1'b0, 1'b1, 8'd60, 8'd60, 5'b00010, 1'b0};
        vecs[5]  = '{3'd2, 1'b1, 1'b0, 8'd60, 8'd60, 5'b00000, 1'b1};
        vecs[6]  = '{3'd3, 1'b1, 1'b1, 8'd60, 8'd60, 5'b00100, 1'b0};
        vecs[7]  = '{3'd4, 1'b0, 1'b1, 8'd60, 8'd60, 5'b01000, 1'b0};
        vecs[8]  = '{3'd4, 1'b1, 1'b0, 8'd60, 8'd60, 5'b00000, 1'b1};
        vecs[9]  = '{3'd5, 1'b0, 1'b0, 8'd30, 8'd60, 5'b10000, 1'b0};
        vecs[10] = '{3'd5, 1'b1, 1'b0, 8'd30, 8'd0,  5'b00000, 1'b1};
        vecs[11] = '{3'd5, 1'b0, 1'b1, 8'd30, 8'd60, 5'b00000, 1'b1};
        vecs[12] = '{3'd0, 1'b0, 1'b0, 8'd60, 8'd60, 5'b00000, 1'b1};
        vecs[13] = '{3'd6, 1'b1, 1'b1, 8'd60, 8'd60, 5'b00000, 1'b1};
        vecs[14] = '{3'd7, 1'b0, 1'b0, 8'd60, 8'd60, 5'b00000, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({pulse, reject, reject_src, brake, busy}), 32'd0);
        check("reset_ready", 32'({btn_ready, rmt_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Legality table, one command per entry.
        foreach (vecs[i]) begin
            wait_idle();
            cruisectrl = vecs[i].ctrl;
            speed = vecs[i].spd;
            cruisespeed = vecs[i].cs;
            if (vecs[i].src) begin
                rmt_valid = 1'b1;
                rmt_cmd = vecs[i].cmd;
            end else begin
                btn_valid = 1'b1;
                btn_cmd = vecs[i].cmd;
            end
            @(posedge clk);
            #1;
            btn_valid = 1'b0;
            rmt_valid = 1'b0;
            check($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(vecs[i].exp_pulse));
            check($sformatf("vec%0d_reject", i), 32'(reject), 32'(vecs[i].exp_rej));
            if (vecs[i].exp_rej) check($sformatf("vec%0d_src", i), 32'(reject_src), 32'(vecs[i].src));
            @(posedge clk);
            #1;
        end

        // Btn SET: one pulse cycle, ready back after hold + gap.
        do_reset();
        cruisectrl = 1'b0;
        speed = 8'd50;
        btn_valid = 1'b1;
        btn_cmd = 3'd1;
        #1;
        check("set_ready_pre", 32'(btn_ready), 32'd1);
        @(posedge clk);
        #1;
        check("set_pulse_n1", 32'(pulse), 32'b00001);
        check("set_ready_n1", 32'(btn_ready), 32'd0);
        @(posedge clk);
        #1;
        check("set_pulse_n2", 32'(pulse), 32'd0);
        check("set_ready_n2", 32'(btn_ready), 32'd0);
        @(posedge clk);
        #1;
        check("set_ready_n3", 32'(btn_ready), 32'd0);
        @(posedge clk);
        #1;
        check("set_ready_idle", 32'(btn_ready), 32'd1);
        check("set_busy_idle", 32'(busy), 32'd0);
        btn_valid = 1'b0;

        // Round robin between both requesters.
        do_reset();
        cruisectrl = 1'b1;
        btn_valid = 1'b1;
        btn_cmd = 3'd2;
        rmt_valid = 1'b1;
        rmt_cmd = 3'd3;
        #1;
        check("rr_ready_first", 32'({btn_ready, rmt_ready}), 32'b10);
        @(posedge clk);
        #1;
        btn_valid = 1'b0;
        check("rr_accel", 32'(pulse), 32'b00010);
        repeat (3) @(posedge clk);
        #1;
        check("rr_rmt_ready", 32'(rmt_ready), 32'd1);
        @(posedge clk);
        #1;
        rmt_valid = 1'b0;
        check("rr_coast", 32'(pulse), 32'b00100);
        wait_idle();
        btn_valid = 1'b1;
        rmt_valid = 1'b1;
        #1;
        check("rr_ptr_back", 32'({btn_ready, rmt_ready}), 32'b10);
        btn_valid = 1'b0;
        rmt_valid = 1'b0;

        // Rejected remote SET.
        do_reset();
        cruisectrl = 1'b0;
        speed = 8'd40;
        rmt_valid = 1'b1;
        rmt_cmd = 3'd1;
        @(posedge clk);
        #1;
        rmt_valid = 1'b0;
        check("rej_flags", 32'({reject, reject_src}), 32'b11);
        check("rej_no_pulse", 32'(pulse), 32'd0);
        @(posedge clk);
        #1;
        check("rej_one_cycle", 32'(reject), 32'd0);
        check("rej_idle", 32'(busy), 32'd0);
`ifdef CRUISE_SEQ_STATS_EN
        check("rej_drop_count", 32'(drop_count), 32'd1);
`endif

        // Brake during a 3-cycle RESUME pulse (second instance).
        do_reset();
        cruisectrl = 1'b0;
        cruisespeed = 8'd60;
        btn_valid = 1'b1;
        btn_cmd = 3'd5;
        @(posedge clk);
        #1;
        btn_valid = 1'b0;
        check("brk_resume_c1", 32'(pulse3), 32'b10000);
        @(posedge clk);
        #1;
        check("brk_resume_c2", 32'(pulse3), 32'b10000);
        brake_in = 1'b1;
        btn_valid = 1'b1;
        #1;
        check("brk_ready_low", 32'(btn_ready3), 32'd0);
        check("brk_brake_lag", 32'(brake3), 32'd0);
        @(posedge clk);
        #1;
        check("brk_resume_off", 32'(pulse3), 32'd0);
        check("brk_brake_out", 32'(brake3), 32'd1);
        check("brk_idle", 32'(busy3), 32'd0);
        check("brk_ready_idle", 32'(btn_ready3), 32'd0);
        brake_in = 1'b0;
        btn_valid = 1'b0;
        @(posedge clk);
        #1;
        check("brk_brake_clear", 32'(brake3), 32'd0);

        // Reset asserted mid-gap.
        do_reset();
        cruisectrl = 1'b0;
        speed = 8'd50;
        btn_valid = 1'b1;
        btn_cmd = 3'd1;
        @(posedge clk);
        #1;
        btn_valid = 1'b0;
        check("gaprst_set", 32'(pulse), 32'b00001);
        @(posedge clk);
        #1;
        check("gaprst_in_gap", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("gaprst_cleared", 32'({pulse, reject, brake, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cruisectrl = 1'b1;
        btn_valid = 1'b1;
        btn_cmd = 3'd4;
        #1;
        check("gaprst_ready", 32'(btn_ready), 32'd1);
        @(posedge clk);
        #1;
        btn_valid = 1'b0;
        check("gaprst_cancel", 32'(pulse), 32'b01000);

        // Randomized traffic against the window model.
        do_reset();
        model_init();
        rand_drive();
        #1;
        for (int i = 0; i < 600; i++) begin
            idle = (cyc >= m_idle_from);
            can = idle && !brake_in;
            check("rnd_ready", 32'({btn_ready, rmt_ready}),
                  32'({can && btn_valid && (!rmt_valid || !m_ptr),
                       can && rmt_valid && (!btn_valid || m_ptr)}));
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            ep = 5'b00000;
            if (cyc >= m_pfirst && cyc <= m_plast) ep[m_code-1] = 1'b1;
            check("rnd_outputs", 32'({pulse, reject, reject_src & reject, busy, brake}),
                  32'({ep, m_rej == cyc, (m_rej == cyc) && m_rsrc, cyc < m_idle_from, m_brake}));
`ifdef CRUISE_SEQ_STATS_EN
            check("rnd_drops", 32'(drop_count), 32'(m_drops));
`endif
            rand_drive();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
